// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding buffer so that
// consecutive words stream out with no idle gap between them.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             shift_en,
   output logic             so,
   output logic             so_valid,
   output logic             done,
   output logic             busy,
   output logic             state_dbg
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             hold_full_q, hold_full_d;
   logic             so_q, so_d;
   logic             done_q, done_d;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] sreg_shifted;

   // Bit that sits at the output end of a word for the chosen bit order.
   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) return w[WIDTH-1];
      else           return w[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
      else           return {1'b0, w[WIDTH-1:1]};
   endfunction

   // Handshake: a word transfers on an edge where din_valid and din_ready are both 1.
   assign din_ready    = ~hold_full_q;
   assign accept       = din_valid & ~hold_full_q;
   assign last_bit     = (cnt_q == LAST_CNT);
   assign sreg_shifted = shift_word(sreg_q);

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      hold_full_d = hold_full_q;
      so_d        = so_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            so_d        = 1'b0;
            hold_full_d = 1'b0;
            if (accept) begin
               sreg_d  = din;
               cnt_d   = '0;
               so_d    = out_bit(din);
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (shift_en && last_bit) begin
               done_d = 1'b1;
               cnt_d  = '0;
               if (hold_full_q) begin
                  sreg_d      = hold_q;
                  so_d        = out_bit(hold_q);
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  // Same-edge bypass straight into the shift register.
                  sreg_d = din;
                  so_d   = out_bit(din);
               end else begin
                  so_d    = 1'b0;
                  state_d = IDLE;
               end
            end else begin
               if (shift_en) begin
                  sreg_d = sreg_shifted;
                  so_d   = out_bit(sreg_shifted);
                  cnt_d  = cnt_q + CW'(1);
               end
               if (accept) begin
                  hold_d      = din;
                  hold_full_d = 1'b1;
               end
            end
         end

         default: begin
            state_d     = IDLE;
            so_d        = 1'b0;
            hold_full_d = 1'b0;
            cnt_d       = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
         so_q        <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
         so_q        <= so_d;
         done_q      <= done_d;
      end
   end

   assign so        = so_q;
   assign so_valid  = (state_q == SHIFT);
   assign done      = done_q;
   assign busy      = so_valid | hold_full_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance
// sharing clock and reset, each scenario in its own task.
module tb_piso_serializer;

   logic       clk;
   logic       rst_n;

   logic [3:0] m_din;
   logic       m_din_valid, m_din_ready, m_shift_en;
   logic       m_so, m_so_valid, m_done, m_busy, m_state;

   logic [3:0] l_din;
   logic       l_din_valid, l_din_ready, l_shift_en;
   logic       l_so, l_so_valid, l_done, l_busy, l_state;

   int pass_cnt;
   int total_cnt;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .din(m_din), .din_valid(m_din_valid),
      .din_ready(m_din_ready), .shift_en(m_shift_en), .so(m_so),
      .so_valid(m_so_valid), .done(m_done), .busy(m_busy), .state_dbg(m_state)
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .din(l_din), .din_valid(l_din_valid),
      .din_ready(l_din_ready), .shift_en(l_shift_en), .so(l_so),
      .so_valid(l_so_valid), .done(l_done), .busy(l_busy), .state_dbg(l_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_din = '0; m_din_valid = 1'b0; m_shift_en = 1'b0;
      l_din = '0; l_din_valid = 1'b0; l_shift_en = 1'b0;
      #2;
      total_cnt++;
      if ({m_so, m_so_valid, m_done, m_busy, m_din_ready, m_state} !== 6'b000010)
         $display("FAIL reset_msb: got so/sv/done/busy/rdy/st=%b expected 000010",
                  {m_so, m_so_valid, m_done, m_busy, m_din_ready, m_state});
      else pass_cnt++;
      total_cnt++;
      if ({l_so, l_so_valid, l_done, l_busy, l_din_ready, l_state} !== 6'b000010)
         $display("FAIL reset_lsb: got so/sv/done/busy/rdy/st=%b expected 000010",
                  {l_so, l_so_valid, l_done, l_busy, l_din_ready, l_state});
      else pass_cnt++;
      tick();
      tick();
      rst_n = 1'b1;
      // shift_en and din alone must not start anything in IDLE
      m_shift_en = 1'b1;
      m_din = 4'hF;
      tick();
      tick();
      total_cnt++;
      if ({m_so, m_so_valid, m_done, m_busy} !== 4'b0000)
         $display("FAIL idle_no_effect: got so/sv/done/busy=%b expected 0000",
                  {m_so, m_so_valid, m_done, m_busy});
      else pass_cnt++;
   endtask

   task automatic test_single_word();
      logic [3:0] w;
      w = 4'b1011;
      m_din = w; m_din_valid = 1'b1; m_shift_en = 1'b1;
      tick();
      m_din_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if ({m_so, m_so_valid, m_done} !== {w[3-i], 1'b1, 1'b0})
            $display("FAIL single_bit[%0d]: got so/sv/done=%b expected %b",
                     i, {m_so, m_so_valid, m_done}, {w[3-i], 1'b1, 1'b0});
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if ({m_so, m_so_valid, m_done} !== 3'b001)
         $display("FAIL single_done: got so/sv/done=%b expected 001",
                  {m_so, m_so_valid, m_done});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({m_done, m_busy, m_state} !== 3'b000)
         $display("FAIL single_idle: got done/busy/st=%b expected 000",
                  {m_done, m_busy, m_state});
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] s;
      logic       exp_rdy;
      int         done_seen;
      s = 8'b1010_0101;
      done_seen = 0;
      m_din = 4'hA; m_din_valid = 1'b1; m_shift_en = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         exp_rdy = !(i >= 1 && i <= 3);
         total_cnt++;
         if ({m_so, m_so_valid, m_busy, m_din_ready, m_done} !==
             {s[7-i], 1'b1, 1'b1, exp_rdy, (i == 4)})
            $display("FAIL b2b_bit[%0d]: got so/sv/busy/rdy/done=%b expected %b",
                     i, {m_so, m_so_valid, m_busy, m_din_ready, m_done},
                     {s[7-i], 1'b1, 1'b1, exp_rdy, (i == 4)});
         else pass_cnt++;
         if (m_done) done_seen++;
         if (i == 0) begin
            m_din = 4'h5; m_din_valid = 1'b1;
         end else begin
            m_din = 4'hF; m_din_valid = (i == 3);  // offered while hold is full: ignored
         end
         tick();
      end
      if (m_done) done_seen++;
      m_din_valid = 1'b0;
      total_cnt++;
      if (m_so_valid !== 1'b0 || done_seen != 2)
         $display("FAIL b2b_end: got so_valid=%b done_pulses=%0d expected 0 and 2",
                  m_so_valid, done_seen);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_bypass();
      logic [7:0] s;
      s = 8'b1100_0011;
      m_din = 4'hC; m_din_valid = 1'b1; m_shift_en = 1'b1;
      tick();
      m_din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         total_cnt++;
         if ({m_so, m_so_valid, m_done} !== {s[7-i], 1'b1, (i == 4)})
            $display("FAIL bypass_bit[%0d]: got so/sv/done=%b expected %b",
                     i, {m_so, m_so_valid, m_done}, {s[7-i], 1'b1, (i == 4)});
         else pass_cnt++;
         m_din = 4'h3;
         m_din_valid = (i == 3);
         tick();
      end
      total_cnt++;
      if ({m_so_valid, m_done} !== 2'b01)
         $display("FAIL bypass_end: got sv/done=%b expected 01", {m_so_valid, m_done});
      else pass_cnt++;
      tick();
   endtask

   task automatic test_throttle();
      logic [3:0] w;
      w = 4'b0110;
      m_din = w; m_din_valid = 1'b1; m_shift_en = 1'b0;
      tick();
      m_din_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         total_cnt++;
         if ({m_so, m_so_valid, m_done} !== {w[3-k/3], 1'b1, 1'b0})
            $display("FAIL throttle[%0d]: got so/sv/done=%b expected %b",
                     k, {m_so, m_so_valid, m_done}, {w[3-k/3], 1'b1, 1'b0});
         else pass_cnt++;
         m_shift_en = ((k % 3) == 2);
         tick();
      end
      m_shift_en = 1'b0;
      total_cnt++;
      if ({m_so_valid, m_done} !== 2'b01)
         $display("FAIL throttle_end: got sv/done=%b expected 01", {m_so_valid, m_done});
      else pass_cnt++;
      tick();
   endtask

   task automatic test_lsb_and_reset();
      logic [3:0] w;
      w = 4'b0001;
      l_din = w; l_din_valid = 1'b1; l_shift_en = 1'b1;
      tick();
      l_din_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if ({l_so, l_so_valid} !== {w[i], 1'b1})
            $display("FAIL lsb_bit[%0d]: got so/sv=%b expected %b",
                     i, {l_so, l_so_valid}, {w[i], 1'b1});
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if ({l_so, l_so_valid, l_done} !== 3'b001)
         $display("FAIL lsb_done: got so/sv/done=%b expected 001", {l_so, l_so_valid, l_done});
      else pass_cnt++;
      tick();

      // second run: reset after two bits with a word also waiting in the hold buffer
      w = 4'b1101;
      l_din = w; l_din_valid = 1'b1;
      tick();
      l_din = 4'b1111;
      total_cnt++;
      if (l_so !== w[0])
         $display("FAIL lsb_rst_bit0: got %b expected %b", l_so, w[0]);
      else pass_cnt++;
      tick();
      l_din_valid = 1'b0;
      total_cnt++;
      if ({l_so, l_busy, l_din_ready} !== {w[1], 1'b1, 1'b0})
         $display("FAIL lsb_rst_bit1: got so/busy/rdy=%b expected %b",
                  {l_so, l_busy, l_din_ready}, {w[1], 1'b1, 1'b0});
      else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({l_so, l_so_valid, l_din_ready, l_busy, l_done} !== 5'b00100)
         $display("FAIL async_reset: got so/sv/rdy/busy/done=%b expected 00100",
                  {l_so, l_so_valid, l_din_ready, l_busy, l_done});
      else pass_cnt++;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if ({l_so_valid, l_done, l_busy} !== 3'b000)
            $display("FAIL post_reset[%0d]: got sv/done/busy=%b expected 000",
                     i, {l_so_valid, l_done, l_busy});
         else pass_cnt++;
      end

      w = 4'b0110;
      l_din = w; l_din_valid = 1'b1;
      tick();
      l_din_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if ({l_so, l_so_valid, l_done} !== {w[i], 1'b1, 1'b0})
            $display("FAIL lsb_restart[%0d]: got so/sv/done=%b expected %b",
                     i, {l_so, l_so_valid, l_done}, {w[i], 1'b1, 1'b0});
         else pass_cnt++;
         tick();
      end
      total_cnt++;
      if ({l_so_valid, l_done} !== 2'b01)
         $display("FAIL lsb_restart_end: got sv/done=%b expected 01", {l_so_valid, l_done});
      else pass_cnt++;
      tick();
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_bypass();
      test_throttle();
      test_lsb_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: word width in bits, minimum 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 din  input  WIDTH  parallel word to transmit.
REQ-006 din_valid  input  1  din holds a word to transmit.
REQ-007 din_ready  output  1  block can accept a word; a transfer happens on an edge where din_valid=1 and din_ready=1.
REQ-008 shift_en  input  1  bit strobe; the current bit retires on an edge where shift_en=1.
REQ-009 so  output  1  serial data out, registered.
REQ-010 so_valid  output  1  so carries a frame bit, registered.
REQ-011 done  output  1  one-cycle pulse after the last bit of a word retires.
REQ-012 busy  output  1  equals so_valid OR hold_full.

Function
REQ-013 Storage SHALL be a WIDTH-bit shift register, a bit counter with range 0..WIDTH-1, a one-word holding buffer, and a hold_full flag.
REQ-014 The state machine SHALL have two states, IDLE and SHIFT; so_valid SHALL be 1 exactly when the state is SHIFT.
REQ-015 din_ready SHALL equal NOT hold_full; hold_full SHALL always be 0 in IDLE.
REQ-016 IDLE with an accepted word: din loads into the shift register, the counter clears to 0, and the state becomes SHIFT; the first bit SHALL appear on so in the next cycle (1-cycle latency).
REQ-017 SHIFT with shift_en=0: the shift register, counter and so SHALL hold.
REQ-018 SHIFT with shift_en=1 and counter < WIDTH-1: the register shifts toward the output end, the next bit goes to so, and the counter increments.
REQ-019 SHIFT with a word accepted on a non-last-bit edge: din SHALL go into the holding buffer and hold_full SHALL become 1.
REQ-020 Last-bit edge (SHIFT, shift_en=1, counter=WIDTH-1): done SHALL be 1 in the following cycle, then return to 0; the next action depends on the three cases below.
REQ-021 Last-bit edge with hold_full=1: the holding buffer moves into the shift register, the counter clears to 0, hold_full clears to 0, and the state stays SHIFT; there SHALL be no idle gap between words.
REQ-022 Last-bit edge with hold_full=0 and a word accepted on the same edge: din SHALL bypass into the shift register, with no gap.
REQ-023 Last-bit edge with hold_full=0 and no word accepted: the state becomes IDLE and so_valid and so go to 0.
REQ-024 Last-bit edge with hold_full=1 and din_valid=1: din_ready=0 on that edge, so no transfer occurs and din is ignored.
REQ-025 In IDLE, so SHALL be 0; din and shift_en SHALL have no effect in IDLE except through a word accepted under REQ-016.
REQ-026 Bit order SHALL follow MSB_FIRST; word content SHALL be transmitted unmodified.

Reset
REQ-027 While rst_n=0 the block SHALL be asynchronously in IDLE with so=0, so_valid=0, done=0, busy=0, din_ready=1, counter=0 and hold_full=0.
REQ-028 Reset mid-frame SHALL drop the partial word and any held word, and SHALL NOT produce a done pulse.
REQ-029 Release of rst_n SHALL take effect on the first rising clk edge after deassertion.

Verification
REQ-030 The bench SHALL cover the following scenarios with WIDTH=4:
- Reset: rst_n=0 mid-simulation -> so=0, so_valid=0, din_ready=1, busy=0 immediately, without waiting for a clock edge.
- Single word: din=4'b1011, MSB_FIRST=1, shift_en held 1 -> so = 1,0,1,1 over 4 cycles; so_valid high for exactly 4 cycles; done high for 1 cycle; then IDLE.
- Back-to-back: 4'hA accepted, then 4'h5 accepted during bit 1 -> 8 contiguous bits 1,0,1,0,0,1,0,1; so_valid never drops; din_ready low from the hold-fill edge until the hold-to-shift-register transfer; done pulses twice.
- Same-edge bypass: hold empty and 4'h3 offered on the last-bit edge of 4'hC -> so = 1,1,0,0,0,0,1,1 with no gap.
- Throttle: shift_en pulsed 1 cycle in every 3, din=4'b0110 -> each bit held for 3 cycles on so.
- LSB-first and reset mid-frame: MSB_FIRST=0, din=4'b0001 -> so = 1,0,0,0; a second run with rst_n=0 after 2 bits -> outputs clear at once, no done, and the next word starts cleanly.
